// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - M-stage load/store bus initiator with stall, alignment check and timeout
// One op per IDLE->BUSY->DONE pass; bus fields are latched at accept and held through BUSY.
module mem_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid_i,
  input  logic [2:0]  op_type_i,
  input  logic [31:0] op_addr_i,
  input  logic [31:0] op_wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_store, is_word, is_half, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Op decode: stores are 101/110/111; the access size picks alignment, lanes and replication.
  always_comb begin
    is_store   = op_type_i[2] & (op_type_i[1] | op_type_i[0]);
    is_word    = (op_type_i == 3'b000) || (op_type_i == 3'b101);
    is_half    = (op_type_i == 3'b001) || (op_type_i == 3'b010) || (op_type_i == 3'b110);
    misaligned = is_word ? (op_addr_i[1:0] != 2'b00) : (is_half ? op_addr_i[0] : 1'b0);
    if (is_word) begin
      be_new    = 4'b1111;
      wdata_new = op_wdata_i;
    end else if (is_half) begin
      be_new    = op_addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{op_wdata_i[15:0]}};
    end else begin
      be_new    = 4'b0001 << op_addr_i[1:0];
      wdata_new = {4{op_wdata_i[7:0]}};
    end
  end

  // Load extraction from the returned word using the latched type and byte offset.
  always_comb begin
    shifted = bus_rdata_i >> {off_q, 3'b000};
    ld_byte = shifted[7:0];
    ld_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (type_q)
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = {16'h0000, ld_half};
      3'b011:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h000000, ld_byte};
      default: ld_ext = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall_o = 1'b0;
    adel_o  = 1'b0;
    ades_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid_i) begin
          if (misaligned) begin
            adel_o = ~is_store;
            ades_o = is_store;
          end else begin
            stall_o = 1'b1;
            type_d  = op_type_i;
            off_d   = op_addr_i[1:0];
            we_d    = is_store;
            addr_d  = {op_addr_i[31:2], 2'b00};
            be_d    = be_new;
            wdata_d = wdata_new;
            cnt_d   = 8'd0;
            err_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (bus_ack_i) begin
          if (!we_q) rdata_d = ld_ext;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      type_q  <= 3'b000;
      off_q   <= 2'b00;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_req_o     = (state_q == BUSY);
  assign bus_we_o      = we_q;
  assign bus_addr_o    = addr_q;
  assign bus_be_o      = be_q;
  assign bus_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state_q == DONE) && !we_q && !err_q;
  assign bus_err_o     = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - scoreboard bench for mem_bus_master with random ops and a reference model
module tb_mem_bus_master;
  localparam int T = 4;
  localparam int K_BUS = 0, K_LOAD = 1, K_ERR = 2, K_ADEL = 3, K_ADES = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_type = 3'b000;
  logic [31:0] op_addr = 32'h0, op_wdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        stall, rdata_valid, adel, ades, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  mem_bus_master #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .op_valid_i(op_valid), .op_type_i(op_type),
    .op_addr_i(op_addr), .op_wdata_i(op_wdata), .stall_o(stall), .rdata_o(rdata),
    .rdata_valid_o(rdata_valid), .adel_o(adel), .ades_o(ades), .bus_err_o(bus_err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
  } ev_t;

  ev_t  sb_q[$];
  ev_t  cur_bus;
  logic prev_req = 1'b0;
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int k);
    ev_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d with empty scoreboard at %0t", k, $time);
      return;
    end
    e = sb_q.pop_front();
    chk("event_kind", k, e.kind);
    if (e.kind != k) return;
    case (k)
      K_BUS: begin
        chk("bus_addr", bus_addr, e.addr);
        chk("bus_be", {28'h0, bus_be}, {28'h0, e.be});
        chk("bus_we", {31'h0, bus_we}, {31'h0, e.we});
        if (e.we) chk("bus_wdata", bus_wdata, e.data);
        cur_bus = e;
      end
      K_LOAD: chk("load_rdata", rdata, e.data);
      K_ERR: begin
        chk("timeout_rdata", rdata, 32'h0);
        chk("timeout_no_valid", {31'h0, rdata_valid}, 32'h0);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (bus_req === 1'b1) begin
      if (!prev_req) expect_ev(K_BUS);
      else begin
        chk("bus_addr_stable", bus_addr, cur_bus.addr);
        chk("bus_be_stable", {28'h0, bus_be}, {28'h0, cur_bus.be});
      end
    end
    if (adel === 1'b1) expect_ev(K_ADEL);
    if (ades === 1'b1) expect_ev(K_ADES);
    if (rdata_valid === 1'b1) expect_ev(K_LOAD);
    if (bus_err === 1'b1) expect_ev(K_ERR);
    prev_req <= (bus_req === 1'b1);
  end

  function automatic int size_of(input logic [2:0] t);
    if (t == 3'd0 || t == 3'd5) return 4;
    if (t == 3'd1 || t == 3'd2 || t == 3'd6) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int sh;
    case (t)
      3'd1, 3'd2: begin
        sh = a[1] ? 16 : 0;
        v = (w >> sh) & 32'h0000_ffff;
        if (t == 3'd1 && v[15]) v = v | 32'hffff_0000;
      end
      3'd3, 3'd4: begin
        sh = 8 * int'(a[1:0]);
        v = (w >> sh) & 32'h0000_00ff;
        if (t == 3'd3 && v[7]) v = v | 32'hffff_ff00;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input int waitc, input logic [31:0] word);
    ev_t e;
    int  size, nbusy, stall_cnt, req_cnt;
    bit  store, tmo;
    size  = size_of(t);
    store = (t >= 3'd5);
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = t; op_addr = a; op_wdata = wd; bus_ack = 1'b0;
    if ((int'(a[1:0]) % size) != 0) begin
      e = '{kind: (store ? K_ADES : K_ADEL), data: 32'h0, addr: 32'h0, be: 4'h0, we: 1'b0};
      sb_q.push_back(e);
      @(negedge clk);
      chk("misaligned_stall", {31'h0, stall}, 32'h0);
      chk("misaligned_no_req", {31'h0, bus_req}, 32'h0);
      return;
    end
    e.kind = K_BUS;
    e.addr = a & 32'hffff_fffc;
    e.we   = store;
    e.be   = (size == 4) ? 4'hf : ((size == 2) ? (4'h3 << a[1:0]) : (4'h1 << a[1:0]));
    e.data = (size == 4) ? wd : ((size == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}});
    sb_q.push_back(e);
    tmo   = (waitc >= T);
    nbusy = tmo ? T : waitc + 1;
    if (tmo) begin
      e = '{kind: K_ERR, data: 32'h0, addr: 32'h0, be: 4'h0, we: 1'b0};
      sb_q.push_back(e);
    end else if (!store) begin
      e = '{kind: K_LOAD, data: model_load(t, a, word), addr: 32'h0, be: 4'h0, we: 1'b0};
      sb_q.push_back(e);
    end
    @(negedge clk);
    stall_cnt = int'(stall);
    req_cnt   = int'(bus_req);
    for (int c = 1; c <= nbusy + 1; c++) begin
      @(posedge clk); #1;
      if (c <= nbusy) begin
        op_valid  = 1'($urandom_range(0, 1));
        op_type   = 3'($urandom);
        op_addr   = $urandom;
        bus_ack   = (c == waitc + 1);
        bus_rdata = bus_ack ? word : $urandom;
      end else begin
        op_valid  = 1'b1; op_type = t; op_addr = a; op_wdata = wd;
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      @(negedge clk);
      stall_cnt += int'(stall);
      req_cnt   += int'(bus_req);
    end
    chk("stall_cycles", stall_cnt, nbusy + 1);
    chk("req_cycles", req_cnt, nbusy);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      op_valid = 1'b0; bus_ack = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    chk({tag, "_bus_req"}, {31'h0, bus_req}, 32'h0);
    chk({tag, "_bus_we"}, {31'h0, bus_we}, 32'h0);
    chk({tag, "_bus_be"}, {28'h0, bus_be}, 32'h0);
    chk({tag, "_bus_addr"}, bus_addr, 32'h0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_rdata_valid"}, {31'h0, rdata_valid}, 32'h0);
    chk({tag, "_bus_err"}, {31'h0, bus_err}, 32'h0);
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] a;
    ev_t         e;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(3'd0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
    run_op(3'd3, 32'h0000_0013, 32'h0, 1, 32'h80FF_0000);
    run_op(3'd4, 32'h0000_0013, 32'h0, 0, 32'h80FF_0000);
    run_op(3'd1, 32'h0000_0012, 32'h0, 2, 32'h80FF_0000);
    run_op(3'd7, 32'h0000_0021, 32'h1234_56AB, 3, 32'h0);
    run_op(3'd6, 32'h0000_0031, 32'h5555_AAAA, 0, 32'h0);
    run_op(3'd0, 32'h0000_0042, 32'h0, 0, 32'h0);
    run_op(3'd0, 32'h0000_0044, 32'h0, 10, 32'hFFFF_FFFF);
    idle(2);

    e = '{kind: K_BUS, data: 32'hCAFE_F00D, addr: 32'h0000_0050, be: 4'hf, we: 1'b1};
    sb_q.push_back(e);
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 3'd5; op_addr = 32'h0000_0050; op_wdata = 32'hCAFE_F00D; bus_ack = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_busy_reset");
    run_op(3'd0, 32'h0000_0060, 32'h0, 1, 32'h0BAD_CAFE);

    for (int i = 0; i < 150; i++) begin
      t = 3'($urandom_range(0, 7));
      a = $urandom & 32'hffff_fffc;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(0, 3));
      else a[1:0] = 2'($urandom_range(0, 3) & ~(size_of(t) - 1));
      run_op(t, a, $urandom, $urandom_range(0, 5), $urandom);
    end
    idle(3);
    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Memory-stage bus initiator for the pipelined MIPS core. It accepts one load or store per M-stage instruction and runs a request/acknowledge transaction to an external data memory with word-aligned address, byte enables and lane-replicated write data. It stalls the pipeline until the memory answers, then returns sign- or zero-extended load data. It also flags misaligned accesses and bus timeouts instead of issuing them.

## Interface
- TIMEOUT, 16: maximum BUSY cycles without `bus_ack` before the transaction is aborted (range 1..255).
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  M stage holds a memory instruction
- op_type  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
- op_addr  in  32  byte address (ALU result)
- op_wdata  in  32  store source register value
- stall  out  1  freeze PC/F/D/E/M pipeline registers
- rdata  out  32  extended load result
- rdata_valid  out  1  one-cycle pulse; `rdata` is valid
- adel  out  1  load address error pulse
- ades  out  1  store address error pulse
- bus_err  out  1  timeout pulse
- bus_req  out  1  request to memory, held until ack
- bus_we  out  1  1 = store
- bus_addr  out  32  {op_addr[31:2],2'b00}
- bus_be  out  4  byte-lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  memory completion, sampled only in BUSY
- bus_rdata  in  32  read word, valid when `bus_ack`=1

## Operation
- FSM states: IDLE, BUSY, DONE.
- Misalignment: lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]≠0.
- IDLE, op_valid, aligned: latch type, addr[1:0], be, wdata, we. `stall`=1 (combinational). Next state BUSY.
- IDLE, op_valid, misaligned: no bus transaction, `stall`=0. `adel` (loads) or `ades` (stores) =1 combinationally that cycle. Stay IDLE.
- BUSY: `bus_req` and bus fields are registered and stable for the whole state. `stall`=1, and an 8-bit counter increments.
  - `bus_ack`=1: latch `bus_rdata`, go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: go to DONE with error flag set and latched data = 0.
- DONE: `bus_req`=0, `stall`=0. `rdata_valid`=1 for loads without error. `bus_err`=1 if timed out. Next state IDLE unconditionally. The op presented during DONE is the completed one and is not re-accepted.
- Byte enables:
  - sw: 1111.
  - sh: 0011 if addr[1]=0, else 1100.
  - sb: 0001 shifted left by addr[1:0].
  - Loads: same mask as the equivalent store size, with `bus_we`=0.
- Write data:
  - sw: op_wdata.
  - sh: {wd[15:0],wd[15:0]}.
  - sb: {4{wd[7:0]}}.
- Load extraction from the latched word w:
  - lb/lbu: byte w[8k+7:8k] with k=addr[1:0]; sign extends from bit 7, zero extends.
  - lh/lhu: half w[15:0] (addr[1]=0) or w[31:16]; extended to 32 bits from bit 15.
  - lw: w.
- `rdata` holds its last value until the next load completes; it is 0 after a timeout.
- `bus_ack` outside BUSY is ignored.
- `op_valid` changing while in BUSY is ignored; the latched op completes.

## Timing
- Reset: state IDLE, counter 0. `bus_req`, `bus_we`, `bus_be`, `rdata_valid`, `bus_err` = 0. `bus_addr`, `bus_wdata`, `rdata` = 0. `stall`=0 unless `op_valid` is high in IDLE after reset.
- Reset mid-BUSY: `bus_req` drops at that edge and the transaction is abandoned; no `rdata_valid` or `bus_err`.
- Minimum latency (ack in first BUSY cycle): accept cycle + BUSY + DONE = 3 cycles, with `stall` high for 2.
- Each extra wait cycle adds one BUSY cycle.
- Timeout: exactly TIMEOUT BUSY cycles, then DONE.
- Back-to-back ops: the next op is accepted in the IDLE cycle after DONE. Peak throughput is one op per 3 cycles.
- Address error pulses last exactly the cycle `op_valid` is presented; the pipeline is not stalled by them.

## Test plan
- lw at 0x0000_0010, ack on first BUSY cycle with rdata 0xDEADBEEF -> `bus_addr`=0x10, `bus_be`=1111, `bus_we`=0; `stall` high 2 cycles; `rdata`=0xDEADBEEF with `rdata_valid` in cycle 3.
- lb at 0x13 and lbu at 0x13, word 0x80FF_0000 -> `rdata`=0xFFFF_FF80 and 0x0000_0080; lh at 0x12 -> 0xFFFF_80FF.
- sb at 0x21 with wdata 0x1234_56AB, ack after 3 wait cycles -> `bus_be`=0010, `bus_wdata`=0xABAB_ABAB, `bus_we`=1; `stall` high 5 cycles; no `rdata_valid`.
- sh at 0x31 -> `ades`=1 for one cycle, `bus_req` never asserted, `stall`=0; lw at 0x42 -> `adel`=1.
- TIMEOUT=4, lw with `bus_ack` tied 0 -> `bus_req` high exactly 4 cycles; DONE cycle `bus_err`=1, `rdata`=0, `rdata_valid`=0; FSM back to IDLE.
- `reset` asserted in the second BUSY cycle of an unacked sw -> next cycle `bus_req`=0, `stall`=0, all outputs at reset values; a following lw completes normally.
